// File: rtl/dds_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dds_pkg                                                                    |
// | Shared defaults, FSM encoding and word type for the DDS output register.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package dds_pkg;

    localparam int SAMPLE_W_DEF = 12;
    localparam int LANES_DEF    = 8;

    typedef logic [2:0] dds_state_t;

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_ARMED  = 3'd1;
    localparam logic [2:0] c_ST_STREAM = 3'd2;
    localparam logic [2:0] c_ST_FLUSH  = 3'd3;
    localparam logic [2:0] c_ST_DRAIN  = 3'd4;

    // Word layout for the default geometry; the top re-declares it per its own parameters.
    typedef struct packed {
        logic                                 last;
        logic [LANES_DEF*SAMPLE_W_DEF-1:0]    data;
    } dds_word_t;

endpackage : dds_pkg
`default_nettype wire

// File: rtl/dds_word_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dds_word_fifo                                                              |
// | Synchronous first-word-fall-through FIFO; head word visible when !empty.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module dds_word_fifo #(
    parameter int WIDTH = 97,
    parameter int DEPTH = 16
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int c_AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW:0]    r_wr_ptr;
    logic [c_AW:0]    r_rd_ptr;
    logic             w_do_pop;
    logic             w_do_push;

    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                   (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign count = r_wr_ptr - r_rd_ptr;

    // A pop in the same cycle frees the slot, so a full FIFO still accepts a push.
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    assign dout = r_mem[r_rd_ptr[c_AW-1:0]];

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr[c_AW-1:0]] <= din;
                r_wr_ptr                  <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

endmodule : dds_word_fifo
`default_nettype wire

// File: rtl/dds_out_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dds_out_reg                                                                |
// | Packs the framed sine-ROM sample stream into DAC words and buffers them.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module dds_out_reg
    import dds_pkg::*;
#(
    parameter int SAMPLE_W   = SAMPLE_W_DEF,
    parameter int LANES      = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int ROM_LAT    = 1
) (
    input  logic                         CLK,
    input  logic                         RESET,
    input  logic [SAMPLE_W-1:0]          SAMPLE_IN,
    input  logic                         SIGN_START_CALC,
    input  logic                         SIGN_STOP_CALC,
    output logic                         OUT_REG_READY,
    output logic [LANES*SAMPLE_W-1:0]    DAC_DATA,
    output logic                         DAC_VALID,
    input  logic                         DAC_READY,
    output logic                         DAC_LAST,
    output logic                         OVERFLOW
);

    localparam int c_DATA_W = LANES * SAMPLE_W;
    localparam int c_LANE_W = $clog2(LANES);
    localparam int c_CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam logic [c_LANE_W-1:0] c_LANE_LAST = c_LANE_W'(LANES - 1);

    typedef struct packed {
        logic                last;
        logic [c_DATA_W-1:0] data;
    } word_t;

    dds_state_t           r_state;
    logic                 r_start_d;
    logic                 r_win_open;
    logic [c_LANE_W-1:0]  r_lane;
    logic [c_DATA_W-1:0]  r_pack;
    logic                 r_ovf;

    logic                 w_win_cyc;
    logic                 w_win_stop;
    logic                 w_cap_v;
    logic                 w_cap_stop;
    logic                 w_cap_en;
    logic                 w_lane_full;
    logic                 w_flush_push;
    logic                 w_push;
    word_t                w_push_word;
    word_t                w_head;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_empty;
    logic [c_CNT_W-1:0]   w_count;
    logic                 w_drain_done;

    // Address window in accumulator time: opens when START falls, closes on STOP inclusive.
    assign w_win_cyc  = ((r_state == c_ST_ARMED) && !SIGN_START_CALC) || r_win_open;
    assign w_win_stop = w_win_cyc && SIGN_STOP_CALC;

    generate
        if (ROM_LAT == 0) begin : g_lat_zero
            assign w_cap_v    = w_win_cyc;
            assign w_cap_stop = w_win_stop;
        end else begin : g_lat_pipe
            logic [ROM_LAT-1:0] r_vld_sr;
            logic [ROM_LAT-1:0] r_stop_sr;

            always_ff @(posedge CLK) begin
                if (RESET) begin
                    r_vld_sr  <= '0;
                    r_stop_sr <= '0;
                end else begin
                    r_vld_sr  <= ROM_LAT'({r_vld_sr, w_win_cyc});
                    r_stop_sr <= ROM_LAT'({r_stop_sr, w_win_stop});
                end
            end

            assign w_cap_v    = r_vld_sr[ROM_LAT-1];
            assign w_cap_stop = r_stop_sr[ROM_LAT-1];
        end
    endgenerate

    assign w_cap_en     = w_cap_v && ((r_state == c_ST_ARMED) || (r_state == c_ST_STREAM));
    assign w_lane_full  = w_cap_en && (r_lane == c_LANE_LAST);
    assign w_flush_push = (r_state == c_ST_FLUSH) && (r_lane != '0);
    assign w_push       = w_lane_full || w_flush_push;
    assign w_pop        = !w_empty && DAC_READY;

    // Lanes above the fill point are already zero because the pack register clears per word.
    always_comb begin
        w_push_word      = '0;
        w_push_word.last = 1'b1;
        w_push_word.data = r_pack;
        if (w_lane_full) begin
            w_push_word.last = w_cap_stop;
            w_push_word.data = {SAMPLE_IN, r_pack[c_DATA_W-SAMPLE_W-1:0]};
        end
    end

    // Done once the last buffered word leaves this cycle, so READY rises right after it.
    assign w_drain_done = w_empty || (w_pop && (w_count == c_CNT_W'(1)));

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state    <= c_ST_IDLE;
            r_start_d  <= 1'b0;
            r_win_open <= 1'b0;
            r_lane     <= '0;
            r_pack     <= '0;
            r_ovf      <= 1'b0;
        end else begin
            r_start_d <= SIGN_START_CALC;

            if (w_win_stop) begin
                r_win_open <= 1'b0;
            end else if (w_win_cyc) begin
                r_win_open <= 1'b1;
            end

            if (w_cap_en) begin
                if (r_lane == c_LANE_LAST) begin
                    r_lane <= '0;
                    r_pack <= '0;
                end else begin
                    r_lane <= r_lane + c_LANE_W'(1);
                    r_pack[r_lane*SAMPLE_W +: SAMPLE_W] <= SAMPLE_IN;
                end
            end else if (r_state == c_ST_FLUSH) begin
                r_lane <= '0;
                r_pack <= '0;
            end

            if (w_push && w_full && !w_pop) begin
                r_ovf <= 1'b1;
            end

            case (r_state)
                c_ST_IDLE: begin
                    if (SIGN_START_CALC && !r_start_d) begin
                        r_state <= c_ST_ARMED;
                    end
                end
                c_ST_ARMED: begin
                    if (!SIGN_START_CALC) begin
                        r_state <= (w_cap_en && w_cap_stop) ? c_ST_FLUSH : c_ST_STREAM;
                    end
                end
                c_ST_STREAM: begin
                    if (w_cap_en && w_cap_stop) begin
                        r_state <= c_ST_FLUSH;
                    end
                end
                c_ST_FLUSH: begin
                    if ((r_lane == '0) && w_drain_done) begin
                        r_state <= c_ST_IDLE;
                    end else begin
                        r_state <= c_ST_DRAIN;
                    end
                end
                c_ST_DRAIN: begin
                    if (w_drain_done) begin
                        r_state <= c_ST_IDLE;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    dds_word_fifo #(
        .WIDTH (c_DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLK   (CLK),
        .RESET (RESET),
        .push  (w_push),
        .din   (w_push_word),
        .pop   (w_pop),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    assign DAC_VALID     = !w_empty;
    assign DAC_DATA      = w_head.data;
    assign DAC_LAST      = w_head.last;
    assign OVERFLOW      = r_ovf;
    assign OUT_REG_READY = (r_state == c_ST_IDLE) && w_empty;

endmodule : dds_out_reg
`default_nettype wire

// File: tb/tb_dds_out_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_dds_out_reg                                                             |
// | Directed bench: three instances (default, 2-deep FIFO, 3-cycle ROM).       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_dds_out_reg;

    logic             clk = 1'b0;
    logic             rst;
    logic [2:0]       start, stop, rdy;
    logic [2:0][11:0] req, pa, pb, pc, sin;
    logic [2:0]       ready, valid, last, ovf;
    logic [2:0][95:0] ddata;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int st_cyc, acc_cyc0, rise_cyc0, fall_cyc0;
    bit prev_ready0 = 1'b1;
    logic [1:0]       pstall = '0;
    logic [1:0][96:0] pword;
    logic [96:0] q0[$], q1[$], q2[$];
    logic [96:0] w;

    always #5 clk = ~clk;

    // ROM models: the sample requested in a window cycle returns ROM_LAT cycles later.
    always @(posedge clk) begin
        pa  <= req;
        pb  <= pa;
        pc  <= pb;
        cyc <= cyc + 1;
    end
    assign sin[0] = pa[0];
    assign sin[1] = pa[1];
    assign sin[2] = pc[2];

    dds_out_reg #(.SAMPLE_W(12), .LANES(8), .FIFO_DEPTH(16), .ROM_LAT(1)) u_dut0 (
        .CLK(clk), .RESET(rst), .SAMPLE_IN(sin[0]), .SIGN_START_CALC(start[0]),
        .SIGN_STOP_CALC(stop[0]), .OUT_REG_READY(ready[0]), .DAC_DATA(ddata[0]),
        .DAC_VALID(valid[0]), .DAC_READY(rdy[0]), .DAC_LAST(last[0]), .OVERFLOW(ovf[0]));

    dds_out_reg #(.SAMPLE_W(12), .LANES(8), .FIFO_DEPTH(2), .ROM_LAT(1)) u_dut1 (
        .CLK(clk), .RESET(rst), .SAMPLE_IN(sin[1]), .SIGN_START_CALC(start[1]),
        .SIGN_STOP_CALC(stop[1]), .OUT_REG_READY(ready[1]), .DAC_DATA(ddata[1]),
        .DAC_VALID(valid[1]), .DAC_READY(rdy[1]), .DAC_LAST(last[1]), .OVERFLOW(ovf[1]));

    dds_out_reg #(.SAMPLE_W(12), .LANES(8), .FIFO_DEPTH(16), .ROM_LAT(3)) u_dut2 (
        .CLK(clk), .RESET(rst), .SAMPLE_IN(sin[2]), .SIGN_START_CALC(start[2]),
        .SIGN_STOP_CALC(stop[2]), .OUT_REG_READY(ready[2]), .DAC_DATA(ddata[2]),
        .DAC_VALID(valid[2]), .DAC_READY(rdy[2]), .DAC_LAST(last[2]), .OVERFLOW(ovf[2]));

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // Accepted words are logged mid-cycle; stalled heads must hold.
    always @(negedge clk) begin
        if (valid[0] && rdy[0]) begin
            q0.push_back({last[0], ddata[0]});
            acc_cyc0 <= cyc;
        end
        if (valid[1] && rdy[1]) q1.push_back({last[1], ddata[1]});
        if (valid[2] && rdy[2]) q2.push_back({last[2], ddata[2]});
        if (ready[0] && !prev_ready0) rise_cyc0 <= cyc;
        if (!ready[0] && prev_ready0) fall_cyc0 <= cyc;
        prev_ready0 <= ready[0];
        for (int k = 0; k < 2; k++) begin
            if (pstall[k] && !rst)
                check("hold", {valid[k], last[k], ddata[k]}, {1'b1, pword[k]});
            pstall[k] <= valid[k] && !rdy[k] && !rst;
            pword[k]  <= {last[k], ddata[k]};
        end
    end

    task automatic step(input int k, input bit tog);
        @(posedge clk);
        #1;
        if (tog) rdy[k] = ~rdy[k];
    endtask

    task automatic send_packet(input int k, input int first, input int n, input bit tog);
        step(k, tog);
        start[k] = 1'b1;
        st_cyc   = cyc;
        for (int i = 0; i < n; i++) begin
            step(k, tog);
            start[k] = 1'b0;
            req[k]   = 12'(first + i);
            stop[k]  = (i == n - 1);
        end
        step(k, tog);
        stop[k] = 1'b0;
        req[k]  = '0;
    endtask

    task automatic wait_idle(input int k, input bit tog);
        int n = 0;
        while (ready[k] !== 1'b1 && n < 300) begin
            step(k, tog);
            n++;
        end
        check("idle_timeout", 128'(n < 300), 128'(1));
        step(k, 1'b0);
    endtask

    task automatic take(input int k, output logic [96:0] wd);
        wd = 'x;
        case (k)
            0: if (q0.size() > 0) wd = q0.pop_front();
            1: if (q1.size() > 0) wd = q1.pop_front();
            default: if (q2.size() > 0) wd = q2.pop_front();
        endcase
    endtask

    initial begin
        rst = 1'b1; start = '0; stop = '0; rdy = 3'b111; req = '0;
        repeat (3) step(0, 1'b0);
        rst = 1'b0;
        check("rst_ready", ready[0], 1);
        check("rst_valid", valid[0], 0);
        check("rst_last",  last[0],  0);
        check("rst_data",  ddata[0], 0);
        check("rst_ovf",   ovf[0],   0);
        step(0, 1'b0);

        // 16 samples -> two full words
        send_packet(0, 1, 16, 1'b0);
        wait_idle(0, 1'b0);
        take(0, w); check("t1_w1", w, {1'b0, 96'h008_007_006_005_004_003_002_001});
        take(0, w); check("t1_w2", w, {1'b1, 96'h010_00F_00E_00D_00C_00B_00A_009});
        check("t1_fall", fall_cyc0, st_cyc + 1);
        check("t1_acc",  acc_cyc0,  st_cyc + 18);
        check("t1_rise", rise_cyc0, st_cyc + 19);
        check("t1_cnt",  q0.size(), 0);

        // 13 samples -> padded tail; then a single-sample window
        send_packet(0, 1, 13, 1'b0);
        wait_idle(0, 1'b0);
        take(0, w); check("t2_w1", w, {1'b0, 96'h008_007_006_005_004_003_002_001});
        take(0, w); check("t2_w2", w, {1'b1, 96'h000_000_000_00D_00C_00B_00A_009});
        send_packet(0, 12'h7FF, 1, 1'b0);
        wait_idle(0, 1'b0);
        take(0, w); check("t2_single", w, {1'b1, 96'h000_000_000_000_000_000_000_7FF});
        check("t2_cnt", q0.size(), 0);

        // 2-deep FIFO, sink stalled: words 3..5 dropped
        rdy[1] = 1'b0;
        send_packet(1, 1, 40, 1'b0);
        repeat (4) step(1, 1'b0);
        check("t3_ovf",   ovf[1],   1);
        check("t3_valid", valid[1], 1);
        check("t3_head",  {last[1], ddata[1]}, {1'b0, 96'h008_007_006_005_004_003_002_001});
        check("t3_busy",  ready[1], 0);
        rdy[1] = 1'b1;
        wait_idle(1, 1'b0);
        take(1, w); check("t3_w1", w, {1'b0, 96'h008_007_006_005_004_003_002_001});
        take(1, w); check("t3_w2", w, {1'b0, 96'h010_00F_00E_00D_00C_00B_00A_009});
        check("t3_cnt",  q1.size(), 0);
        check("t3_ovf2", ovf[1], 1);

        // Toggling DAC_READY over 32 samples
        send_packet(0, 1, 32, 1'b1);
        wait_idle(0, 1'b1);
        rdy[0] = 1'b1;
        take(0, w); check("t4_w1", w, {1'b0, 96'h008_007_006_005_004_003_002_001});
        take(0, w); check("t4_w2", w, {1'b0, 96'h010_00F_00E_00D_00C_00B_00A_009});
        take(0, w); check("t4_w3", w, {1'b0, 96'h018_017_016_015_014_013_012_011});
        take(0, w); check("t4_w4", w, {1'b1, 96'h020_01F_01E_01D_01C_01B_01A_019});
        check("t4_ovf", ovf[0], 0);

        // Reset at sample 11 of 24
        step(0, 1'b0);
        start[0] = 1'b1;
        for (int i = 0; i < 11; i++) begin
            step(0, 1'b0);
            start[0] = 1'b0;
            req[0]   = 12'(i + 1);
        end
        rst = 1'b1;
        step(0, 1'b0);
        rst = 1'b0; req[0] = '0;
        check("t5_valid", valid[0], 0);
        check("t5_ready", ready[0], 1);
        q0.delete();
        step(0, 1'b0);
        send_packet(0, 12'h021, 8, 1'b0);
        wait_idle(0, 1'b0);
        take(0, w); check("t5_w1", w, {1'b1, 96'h028_027_026_025_024_023_022_021});
        check("t5_cnt", q0.size(), 0);

        // START pulse during DRAIN is ignored
        rdy[0] = 1'b0;
        send_packet(0, 12'h031, 8, 1'b0);
        repeat (3) step(0, 1'b0);
        start[0] = 1'b1;
        step(0, 1'b0);
        start[0] = 1'b0;
        repeat (3) step(0, 1'b0);
        check("t6_busy", ready[0], 0);
        rdy[0] = 1'b1;
        wait_idle(0, 1'b0);
        repeat (4) step(0, 1'b0);
        take(0, w); check("t6_w1", w, {1'b1, 96'h038_037_036_035_034_033_032_031});
        check("t6_cnt",   q0.size(), 0);
        check("t6_valid", valid[0], 0);
        check("t6_ready", ready[0], 1);

        // ROM_LAT=3 repeat of the 16-sample packet
        send_packet(2, 1, 16, 1'b0);
        wait_idle(2, 1'b0);
        take(2, w); check("t6_lat3_w1", w, {1'b0, 96'h008_007_006_005_004_003_002_001});
        take(2, w); check("t6_lat3_w2", w, {1'b1, 96'h010_00F_00E_00D_00C_00B_00A_009});
        check("t6_lat3_cnt", q2.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_dds_out_reg
`default_nettype wire
